sys_ocm_banked: RTL and testbench
=================================

Name: sys_ocm_banked

Overview:
- Parametrised, banked on-chip memory. Serves the data-side line refill/writeback port and the instruction-fetch port of the core.
- Successor to the single-bank OCM, with these additions:
  - configurable line width, address width, bank count and read latency
  - byte-masked partial writes
  - a pipelined instruction port with one result per accepted request
  - data/insn bank-conflict arbitration
- Sits between the L1 data cache / fetch unit and the SRAM macros.

Parameters:
- ADDR_W, 16, byte address width.
- LINE_W, 128, line width in bits; power of two, at least INSN_W.
- INSN_W, 32, instruction word width.
- BANKS, 2, number of SRAM banks; power of two, at least 1. Bank select is the low line-index bits.
- RD_LAT, 1, SRAM read latency in cycles; legal values 1 or 2.
- SET_W, 5, width of the replace set index.

Derived (package): OFF_W = log2(LINE_W/8); BNK_W = log2(BANKS); IDX_W = ADDR_W-OFF_W-BNK_W; TAG_W = ADDR_W-OFF_W-SET_W.

Ports:
- sys_clk  in  1  clock
- sys_rst_n  in  1  asynchronous active-low reset
- mem_request  in  1  data access request (level)
- mem_finish  out  1  one-cycle completion pulse
- mem_partial  out  1  completed write used a non-full byte mask
- mem_rwn  in  1  1=read line, 0=write line
- mem_addr  in  ADDR_W  byte address; the offset bits are ignored
- mem_commit  in  LINE_W/8  byte write enables
- mem_write_data  in  LINE_W  write line
- mem_replace  out  1  read line returned for refill
- mem_replace_set  out  SET_W  set index of the returned line
- mem_replace_tag  out  TAG_W  tag of the returned line
- mem_replace_dat  out  LINE_W  returned line
- insn_reset  in  1  synchronous flush of the insn pipeline
- insn_request  in  1  fetch request
- insn_stall  out  1  request not accepted this cycle
- insn_valid  out  1  insn_data valid this cycle
- insn_addr  in  ADDR_W  fetch byte address
- insn_data  out  INSN_W  fetched word

Behaviour:
- Reset (sys_rst_n low, async):
  - FSM goes to IDLE.
  - mem_finish, mem_partial, mem_replace, insn_valid and insn_stall are 0.
  - All pipeline valids are cleared; captured address/data registers are cleared to 0.
  - SRAM contents are not affected.
  - A reset mid-operation aborts the access with no mem_finish. A write aborted in ACCESS may or may not have landed.
- Data FSM, IDLE -> ACCESS -> WAIT -> DONE -> IDLE:
  - IDLE: when mem_request=1, capture mem_rwn/addr/commit/write_data and go to ACCESS.
  - ACCESS: exactly one cycle. Enables the addressed bank; a write applies mem_commit byte enables. Go to WAIT if RD_LAT=2, else DONE.
  - WAIT: one cycle, then DONE.
  - DONE: mem_finish=1 for one cycle, then IDLE. mem_request still high in DONE is not re-accepted; it is re-sampled in IDLE.
  - Latency: request sampled at edge t gives mem_finish high in cycle t+1+RD_LAT.
  - Input changes after capture are ignored.
- Data outputs in DONE:
  - mem_replace = mem_finish && captured rwn.
  - set/tag come from the captured address; mem_replace_dat is stable during DONE.
  - mem_partial = mem_finish && !rwn && (commit != all ones).
  - A write with commit=0 completes normally and changes no bytes.
- Insn port:
  - Fully pipelined, one request per cycle.
  - Accepted = insn_request && !insn_stall.
  - Accepted at edge t gives insn_valid=1 with insn_data in cycle t+RD_LAT.
  - The word select (addr[OFF_W-1:log2(INSN_W/8)]) is delayed RD_LAT cycles alongside.
  - insn_valid pulses once per accepted request; it is not sticky.
- Arbitration:
  - insn_stall = insn_request && FSM==ACCESS && bank(insn_addr)==bank(captured addr). Data wins.
  - Different banks proceed in parallel.
  - With BANKS=1, any insn request during ACCESS stalls.
  - The requester holds insn_addr while stalled.
- insn_reset (sync):
  - Clears all in-flight insn valids; no insn_valid the next cycle.
  - A request in the same cycle as insn_reset is dropped.
  - Does not affect the data FSM.
- Read-during-write, same line, different ports: insn returns old data.

Decomposition:
- Package sys_ocm_pkg: derived widths (OFF_W, BNK_W, IDX_W, TAG_W), FSM state encoding, bank-select function.
- Sub-module sys_ocm_bank: one dual-port SRAM bank with byte enables and a RD_LAT output register. Instantiated BANKS times in a generate loop.
- The top level holds the FSM, arbitration, insn pipeline and word mux.

Test Plan:
- RD_LAT=1: write 0x0123..EF at addr 0x0040 with commit=0xFFFF, then read 0x0040. Required: mem_finish at t+2; on the read, mem_replace=1, dat matches, set=0x04, tag=0x00, mem_partial=0 on both.
- Partial write commit=0x000F of 0xAAAA.. over a line holding 0x5555... Required: mem_partial=1; readback has low 4 bytes 0xAA and the rest 0x55.
- Back-to-back insn fetches 0x0000, 0x0004, 0x0008, 0x000C with RD_LAT=2. Required: insn_valid on 4 consecutive cycles starting t+2, returning words 0..3 in order.
- Data write to bank 0 in ACCESS, plus insn fetch to bank 0 and then bank 1. Required: bank-0 fetch sees insn_stall=1 for one cycle and is accepted the next; bank-1 fetch has no stall.
- insn_reset asserted with two fetches in flight. Required: no insn_valid for either; next fetch returns normally.
- sys_rst_n low during WAIT. Required: all outputs 0 immediately, no mem_finish; next request completes with normal latency.

Source files
------------

// File: rtl/sys_ocm_pkg.sv
// sys_ocm_pkg: shared FSM encoding, derived-width helpers and bank select for the banked OCM.
// Widths: OFF_W = line offset bits, BNK_W = bank select bits,
//         IDX_W = row index bits per bank, TAG_W = refill tag bits.
package sys_ocm_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_WAIT, ST_DONE} state_t;
   function automatic int off_w(input int line_w);
      return $clog2(line_w / 8);
   endfunction
   function automatic int bnk_w(input int banks);
      return $clog2(banks);
   endfunction
   function automatic int idx_w(input int addr_w, input int line_w, input int banks);
      return addr_w - off_w(line_w) - bnk_w(banks);
   endfunction
   function automatic int tag_w(input int addr_w, input int line_w, input int set_w);
      return addr_w - off_w(line_w) - set_w;
   endfunction
   // banks is a power of two, so the low line-index bits pick the bank
   function automatic int unsigned bank_sel(input int unsigned line, input int banks);
      return line & 32'(banks - 1);
   endfunction
endpackage

// File: rtl/sys_ocm_bank.sv
// sys_ocm_bank: one dual-port SRAM bank with a RD_LAT-deep read output pipeline.
// Port a: data side, read or byte-masked write of one line.
// Port b: instruction side, read only; a read racing a port-a write returns old data.
// a_q / b_q: read lines, valid RD_LAT cycles after the enabling edge.
module sys_ocm_bank #(
   parameter int LINE_W = 128,
   parameter int IDX_W  = 11,
   parameter int RD_LAT = 1
) (
   input  logic                clk,
   input  logic                a_en,
   input  logic                a_we,
   input  logic [LINE_W/8-1:0] a_be,
   input  logic [IDX_W-1:0]    a_idx,
   input  logic [LINE_W-1:0]   a_wdata,
   output logic [LINE_W-1:0]   a_q,
   input  logic                b_en,
   input  logic [IDX_W-1:0]    b_idx,
   output logic [LINE_W-1:0]   b_q
);
   logic [LINE_W-1:0] mem [2**IDX_W];
   logic [LINE_W-1:0] a_r, b_r;
   always_ff @(posedge clk) begin
      if (a_en && a_we)
         for (int i = 0; i < LINE_W / 8; i++)
            if (a_be[i]) mem[a_idx][8*i +: 8] <= a_wdata[8*i +: 8];
      if (a_en && !a_we) a_r <= mem[a_idx];
      if (b_en) b_r <= mem[b_idx];
   end
   if (RD_LAT == 2) begin : g_lat2
      logic [LINE_W-1:0] a_r2, b_r2;
      always_ff @(posedge clk) begin
         a_r2 <= a_r;
         b_r2 <= b_r;
      end
      assign a_q = a_r2;
      assign b_q = b_r2;
   end else begin : g_lat1
      assign a_q = a_r;
      assign b_q = b_r;
   end
endmodule

// File: rtl/sys_ocm_banked.sv
// sys_ocm_banked: banked on-chip memory serving the data line port and the instruction fetch port.
// mem_*  : data side; a level request is captured in IDLE, runs ACCESS (WAIT) DONE and pulses mem_finish.
//          Reads return the line on mem_replace_* during DONE; mem_partial flags non-full byte masks.
// insn_* : fully pipelined fetch; one insn_valid per accepted request, RD_LAT cycles later.
//          insn_stall when the data side holds the same bank in ACCESS; insn_reset flushes in-flight fetches.
module sys_ocm_banked
   import sys_ocm_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int LINE_W = 128,
   parameter int INSN_W = 32,
   parameter int BANKS  = 2,
   parameter int RD_LAT = 1,
   parameter int SET_W  = 5
) (
   input  logic                                     sys_clk,
   input  logic                                     sys_rst_n,
   input  logic                                     mem_request,
   output logic                                     mem_finish,
   output logic                                     mem_partial,
   input  logic                                     mem_rwn,
   input  logic [ADDR_W-1:0]                        mem_addr,
   input  logic [LINE_W/8-1:0]                      mem_commit,
   input  logic [LINE_W-1:0]                        mem_write_data,
   output logic                                     mem_replace,
   output logic [SET_W-1:0]                         mem_replace_set,
   output logic [tag_w(ADDR_W, LINE_W, SET_W)-1:0]  mem_replace_tag,
   output logic [LINE_W-1:0]                        mem_replace_dat,
   input  logic                                     insn_reset,
   input  logic                                     insn_request,
   output logic                                     insn_stall,
   output logic                                     insn_valid,
   input  logic [ADDR_W-1:0]                        insn_addr,
   output logic [INSN_W-1:0]                        insn_data
);
   localparam int OFF_W = off_w(LINE_W);
   localparam int BNK_W = bnk_w(BANKS);
   localparam int IDX_W = idx_w(ADDR_W, LINE_W, BANKS);
   localparam int TAG_W = tag_w(ADDR_W, LINE_W, SET_W);
   localparam int BW    = BNK_W > 0 ? BNK_W : 1;
   localparam int IOFF  = $clog2(INSN_W / 8);
   localparam int WS_W  = $clog2(LINE_W / INSN_W);
   localparam int WW    = WS_W > 0 ? WS_W : 1;
   state_t state, state_nx;
   logic                rwn_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [LINE_W/8-1:0] commit_q;
   logic [LINE_W-1:0]   wdata_q;
   logic [BW-1:0]       dbank, ibank;
   logic [IDX_W-1:0]    didx, iidx;
   logic [WW-1:0]       iword;
   logic                accept;
   logic [LINE_W-1:0]   a_q [BANKS];
   logic [LINE_W-1:0]   b_q [BANKS];
   logic [LINE_W-1:0]   iline;
   logic                v_d  [RD_LAT];
   logic [BW-1:0]       ib_d [RD_LAT];
   logic [WW-1:0]       ws_d [RD_LAT];
   assign dbank  = BW'(bank_sel(32'(addr_q >> OFF_W), BANKS));
   assign ibank  = BW'(bank_sel(32'(insn_addr >> OFF_W), BANKS));
   assign didx   = IDX_W'(addr_q >> (OFF_W + BNK_W));
   assign iidx   = IDX_W'(insn_addr >> (OFF_W + BNK_W));
   assign iword  = WS_W > 0 ? WW'(insn_addr >> IOFF) : '0;
   // a request dropped by insn_reset never enters the pipeline
   assign accept = insn_request && !insn_stall && !insn_reset;
   always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) state <= ST_IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      unique case (state)
         ST_IDLE:   state_nx = mem_request ? ST_ACCESS : ST_IDLE;
         ST_ACCESS: state_nx = RD_LAT == 2 ? ST_WAIT : ST_DONE;
         ST_WAIT:   state_nx = ST_DONE;
         default:   state_nx = ST_IDLE;
      endcase
      mem_finish  = state == ST_DONE;
      mem_replace = mem_finish && rwn_q;
      mem_partial = mem_finish && !rwn_q && commit_q != '1;
      // data side owns its bank for the single ACCESS cycle
      insn_stall  = insn_request && state == ST_ACCESS && ibank == dbank;
   end
   always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) begin
         rwn_q    <= 1'b0;
         addr_q   <= '0;
         commit_q <= '0;
         wdata_q  <= '0;
      end else if (state == ST_IDLE && mem_request) begin
         rwn_q    <= mem_rwn;
         addr_q   <= mem_addr;
         commit_q <= mem_commit;
         wdata_q  <= mem_write_data;
      end
   always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) begin
         for (int i = 0; i < RD_LAT; i++) begin
            v_d[i]  <= 1'b0;
            ib_d[i] <= '0;
            ws_d[i] <= '0;
         end
      end else begin
         v_d[0]  <= accept;
         ib_d[0] <= ibank;
         ws_d[0] <= iword;
         for (int i = 1; i < RD_LAT; i++) begin
            v_d[i]  <= insn_reset ? 1'b0 : v_d[i-1];
            ib_d[i] <= ib_d[i-1];
            ws_d[i] <= ws_d[i-1];
         end
      end
   for (genvar g = 0; g < BANKS; g++) begin : g_bank
      sys_ocm_bank #(.LINE_W(LINE_W), .IDX_W(IDX_W), .RD_LAT(RD_LAT)) u_bank (
         .clk     (sys_clk),
         .a_en    (state == ST_ACCESS && dbank == BW'(g)),
         .a_we    (!rwn_q),
         .a_be    (commit_q),
         .a_idx   (didx),
         .a_wdata (wdata_q),
         .a_q     (a_q[g]),
         .b_en    (accept && ibank == BW'(g)),
         .b_idx   (iidx),
         .b_q     (b_q[g])
      );
   end
   assign mem_replace_set = addr_q[OFF_W +: SET_W];
   assign mem_replace_tag = addr_q[ADDR_W-1 -: TAG_W];
   assign mem_replace_dat = mem_replace ? a_q[dbank] : '0;
   assign insn_valid      = v_d[RD_LAT-1];
   assign iline           = b_q[ib_d[RD_LAT-1]];
   assign insn_data       = insn_valid ? iline[ws_d[RD_LAT-1]*INSN_W +: INSN_W] : '0;
endmodule

// File: tb/tb_sys_ocm_banked.sv
// tb_sys_ocm_banked: two instances (RD_LAT=1 and RD_LAT=2) on shared stimulus, checked against a line-array model.
module tb_sys_ocm_banked;
   logic sys_clk = 1'b0, sys_rst_n = 1'b0;
   always #5 sys_clk = ~sys_clk;
   logic mem_request = 1'b0, mem_rwn = 1'b0;
   logic [15:0] mem_addr = '0, mem_commit = '0;
   logic [127:0] mem_write_data = '0;
   logic insn_reset = 1'b0, insn_request = 1'b0;
   logic [15:0] insn_addr = '0;
   logic [1:0] fin, part, repl, stall, ivalid;
   logic [1:0][4:0] rset;
   logic [1:0][6:0] rtag;
   logic [1:0][127:0] rdat;
   logic [1:0][31:0] idata;
   int errors = 0, checks = 0;
   logic [127:0] mdl [4096];
   int fn;
   logic [15:0] fa [8];
   bit fr [8], frs [8];
   for (genvar g = 0; g < 2; g++) begin : g_dut
      sys_ocm_banked #(.RD_LAT(g + 1)) u_dut (
         .sys_clk         (sys_clk),
         .sys_rst_n       (sys_rst_n),
         .mem_request     (mem_request),
         .mem_finish      (fin[g]),
         .mem_partial     (part[g]),
         .mem_rwn         (mem_rwn),
         .mem_addr        (mem_addr),
         .mem_commit      (mem_commit),
         .mem_write_data  (mem_write_data),
         .mem_replace     (repl[g]),
         .mem_replace_set (rset[g]),
         .mem_replace_tag (rtag[g]),
         .mem_replace_dat (rdat[g]),
         .insn_reset      (insn_reset),
         .insn_request    (insn_request),
         .insn_stall      (stall[g]),
         .insn_valid      (ivalid[g]),
         .insn_addr       (insn_addr),
         .insn_data       (idata[g])
      );
   end
   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic tick;
      @(posedge sys_clk);
      @(negedge sys_clk);
   endtask
   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction
   function automatic logic [31:0] word(input logic [15:0] a);
      logic [127:0] l;
      l = mdl[a[15:4]];
      return l[32*a[3:2] +: 32];
   endfunction
   // one data access; instance d (latency d+1) must finish exactly d+1 cycles after the ACCESS cycle
   task automatic data_op(input bit rwn, input logic [15:0] a, input logic [15:0] cm, input logic [127:0] wd);
      logic [127:0] want;
      want = mdl[a[15:4]];
      mem_request = 1'b1; mem_rwn = rwn; mem_addr = a; mem_commit = cm; mem_write_data = wd;
      tick;
      mem_request = 1'b0; mem_rwn = 1'($urandom); mem_addr = 16'($urandom);
      mem_commit = 16'($urandom); mem_write_data = rnd128();
      for (int n = 0; n < 4; n++) begin
         for (int d = 0; d < 2; d++) begin
            chk($sformatf("finish%0d_n%0d", d, n), 128'(fin[d]), 128'(n == d + 1));
            if (n == d + 1) begin
               chk($sformatf("replace%0d", d), 128'(repl[d]), 128'(rwn));
               chk($sformatf("partial%0d", d), 128'(part[d]), 128'(!rwn && cm != 16'hffff));
               chk($sformatf("set%0d", d), 128'(rset[d]), 128'((a >> 4) & 16'd31));
               chk($sformatf("tag%0d", d), 128'(rtag[d]), 128'(a >> 9));
               if (rwn) chk($sformatf("rdat%0d_a%h", d, a), rdat[d], want);
            end
         end
         if (n < 3) tick;
      end
      if (!rwn)
         for (int i = 0; i < 16; i++)
            if (cm[i]) mdl[a[15:4]][8*i +: 8] = wd[8*i +: 8];
   endtask
   // fetch schedule fa/fr/frs over fn cycles; a fetch accepted in cycle e shows in cycle e+lat-1
   // unless insn_reset is seen in any later cycle up to then
   task automatic insn_run;
      int e;
      bit v;
      for (int c = 0; c < fn + 2; c++) begin
         insn_request = c < fn && fr[c];
         insn_addr = c < fn ? fa[c] : 16'($urandom);
         insn_reset = c < fn && frs[c];
         #1;
         for (int d = 0; d < 2; d++) chk($sformatf("stall_idle%0d", d), 128'(stall[d]), 128'(0));
         tick;
         for (int d = 0; d < 2; d++) begin
            e = c - d;
            v = e >= 0 && e < fn && fr[e] && !frs[e];
            for (int r = e + 1; r <= c; r++) if (r < fn && frs[r]) v = 1'b0;
            chk($sformatf("ivalid%0d_c%0d", d, c), 128'(ivalid[d]), 128'(v));
            if (v) chk($sformatf("idata%0d_a%h", d, fa[e]), 128'(idata[d]), 128'(word(fa[e])));
         end
      end
      insn_request = 1'b0;
      insn_reset = 1'b0;
   endtask
   initial begin
      #1000000;
      $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end
   initial begin
      logic [127:0] wd;
      repeat (2) @(negedge sys_clk);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("rst_finish%0d", d), 128'(fin[d]), 128'(0));
         chk($sformatf("rst_partial%0d", d), 128'(part[d]), 128'(0));
         chk($sformatf("rst_replace%0d", d), 128'(repl[d]), 128'(0));
         chk($sformatf("rst_stall%0d", d), 128'(stall[d]), 128'(0));
         chk($sformatf("rst_ivalid%0d", d), 128'(ivalid[d]), 128'(0));
      end
      sys_rst_n = 1'b1;
      tick;
      data_op(1'b0, 16'h0040, 16'hffff, 128'h0123456789abcdef_fedcba9876543210);
      data_op(1'b1, 16'h0040, 16'h0000, '0);
      for (int l = 0; l < 64; l++) if (l != 4) data_op(1'b0, 16'(l << 4), 16'hffff, rnd128());
      data_op(1'b0, 16'h0050, 16'hffff, {16{8'h55}});
      data_op(1'b0, 16'h0050, 16'h000f, {16{8'haa}});
      data_op(1'b1, 16'h0050, 16'h0000, '0);
      data_op(1'b0, 16'h0060, 16'h0000, rnd128());
      data_op(1'b1, 16'h0060, 16'hffff, '0);
      fn = 4;
      for (int i = 0; i < 4; i++) begin fa[i] = 16'(4 * i); fr[i] = 1'b1; frs[i] = 1'b0; end
      insn_run;
      // same-bank fetch during the write's ACCESS cycle is held off one cycle
      wd = rnd128();
      mem_request = 1'b1; mem_rwn = 1'b0; mem_addr = 16'h0020; mem_commit = 16'hffff; mem_write_data = wd;
      tick;
      mem_request = 1'b0;
      insn_request = 1'b1; insn_addr = 16'h0004;
      #1;
      for (int d = 0; d < 2; d++) chk($sformatf("stall_b0_%0d", d), 128'(stall[d]), 128'(1));
      tick;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("cf_finish%0d", d), 128'(fin[d]), 128'(d == 0));
         chk($sformatf("cf_stall_off%0d", d), 128'(stall[d]), 128'(0));
         chk($sformatf("cf_novalid%0d", d), 128'(ivalid[d]), 128'(0));
      end
      tick;
      insn_request = 1'b0;
      for (int k = 0; k < 2; k++) begin
         for (int d = 0; d < 2; d++) begin
            chk($sformatf("cf_ivalid%0d_k%0d", d, k), 128'(ivalid[d]), 128'(k == d));
            if (k == d) chk($sformatf("cf_idata%0d", d), 128'(idata[d]), 128'(word(16'h0004)));
         end
         tick;
      end
      mdl[2] = wd;
      // other-bank fetch proceeds alongside the write
      wd = rnd128();
      mem_request = 1'b1; mem_rwn = 1'b0; mem_addr = 16'h0020; mem_commit = 16'hffff; mem_write_data = wd;
      tick;
      mem_request = 1'b0;
      insn_request = 1'b1; insn_addr = 16'h0018;
      #1;
      for (int d = 0; d < 2; d++) chk($sformatf("stall_b1_%0d", d), 128'(stall[d]), 128'(0));
      tick;
      insn_request = 1'b0;
      for (int k = 0; k < 2; k++) begin
         for (int d = 0; d < 2; d++) begin
            chk($sformatf("pb_ivalid%0d_k%0d", d, k), 128'(ivalid[d]), 128'(k == d));
            if (k == d) chk($sformatf("pb_idata%0d", d), 128'(idata[d]), 128'(word(16'h0018)));
         end
         tick;
      end
      tick;
      mdl[2] = wd;
      data_op(1'b1, 16'h0020, 16'hffff, '0);
      fn = 4;
      fa[0] = 16'h0010; fa[1] = 16'h0014; fa[2] = 16'h0020; fa[3] = 16'h0024;
      fr[0] = 1; fr[1] = 1; fr[2] = 0; fr[3] = 1;
      frs[0] = 0; frs[1] = 1; frs[2] = 0; frs[3] = 0;
      insn_run;
      // reset while the RD_LAT=2 instance sits in WAIT
      mem_request = 1'b1; mem_rwn = 1'b1; mem_addr = 16'h0040;
      tick;
      mem_request = 1'b0;
      tick;
      #2 sys_rst_n = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("ar_finish%0d", d), 128'(fin[d]), 128'(0));
         chk($sformatf("ar_replace%0d", d), 128'(repl[d]), 128'(0));
         chk($sformatf("ar_partial%0d", d), 128'(part[d]), 128'(0));
         chk($sformatf("ar_set%0d", d), 128'(rset[d]), 128'(0));
         chk($sformatf("ar_tag%0d", d), 128'(rtag[d]), 128'(0));
         chk($sformatf("ar_dat%0d", d), rdat[d], 128'(0));
         chk($sformatf("ar_ivalid%0d", d), 128'(ivalid[d]), 128'(0));
      end
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      for (int n = 0; n < 3; n++) begin
         tick;
         for (int d = 0; d < 2; d++) chk($sformatf("ar_nofin%0d_%0d", d, n), 128'(fin[d]), 128'(0));
      end
      data_op(1'b1, 16'h0040, 16'hffff, '0);
      for (int it = 0; it < 60; it++) begin
         case ($urandom_range(0, 2))
            0: data_op(1'b0, 16'($urandom_range(0, 1023)), $urandom_range(0, 1) ? 16'hffff : 16'($urandom), rnd128());
            1: data_op(1'b1, 16'($urandom_range(0, 1023)), 16'($urandom), '0);
            default: begin
               fn = $urandom_range(1, 8);
               for (int i = 0; i < fn; i++) begin
                  fa[i] = 16'($urandom_range(0, 255) << 2);
                  fr[i] = $urandom_range(0, 9) < 8;
                  frs[i] = $urandom_range(0, 9) == 0;
               end
               insn_run;
            end
         endcase
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
